veri_bellek_yanitlayici: RTL

//  Responder end of the BIB (bellek islem birimi) data-memory interface driven by the yurut stage.

---
 rtl/veri_bellek_yanitlayici_pkg.sv | 22 ++
 rtl/veri_bellek_yanitlayici_if.sv | 24 ++
 rtl/veri_bellek_sram.sv | 37 +++
 rtl/veri_bellek_yanitlayici.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/veri_bellek_yanitlayici_pkg.sv
// rtl/veri_bellek_yanitlayici_pkg.sv - shared BIB widths, FSM encodings and lane-mask helper
package veri_bellek_yanitlayici_pkg;

    localparam int VBY_VERI_BIT  = 32;
    localparam int VBY_MASKE_BIT = 4;

    typedef enum logic [1:0] {
        VBY_BOSTA = 2'd0,
        VBY_BEKLE = 2'd1,
        VBY_YANIT = 2'd2
    } vby_durum_t;

    // Expands a byte-lane enable into a per-bit mask.
    function automatic logic [VBY_VERI_BIT-1:0] maske_genislet(input logic [VBY_MASKE_BIT-1:0] maske);
        logic [VBY_VERI_BIT-1:0] sonuc;
        for (int i = 0; i < VBY_MASKE_BIT; i++) begin
            sonuc[8*i +: 8] = {8{maske[i]}};
        end
        return sonuc;
    endfunction

endpackage

// File: rtl/veri_bellek_yanitlayici_if.sv
// rtl/veri_bellek_yanitlayici_if.sv - BIB request/response bundle between yurut and the responder
interface veri_bellek_yanitlayici_if;
    import veri_bellek_yanitlayici_pkg::*;

    logic                     bib_sec_i;
    logic [31:0]              bib_adr_i;
    logic [VBY_VERI_BIT-1:0]  bib_veri_i;
    logic [VBY_MASKE_BIT-1:0] bib_veri_maske_i;
    logic                     bib_yaz_gecerli_i;
    logic [VBY_VERI_BIT-1:0]  bib_veri_o;
    logic                     bib_durdur_o;
    logic                     bib_hata_o;

    modport master (
        output bib_sec_i, bib_adr_i, bib_veri_i, bib_veri_maske_i, bib_yaz_gecerli_i,
        input  bib_veri_o, bib_durdur_o, bib_hata_o
    );

    modport slave (
        input  bib_sec_i, bib_adr_i, bib_veri_i, bib_veri_maske_i, bib_yaz_gecerli_i,
        output bib_veri_o, bib_durdur_o, bib_hata_o
    );

endinterface

// File: rtl/veri_bellek_sram.sv
// rtl/veri_bellek_sram.sv - word-wide sync RAM, registered read-before-write, byte-lane write enables
module veri_bellek_sram
    import veri_bellek_yanitlayici_pkg::*;
#(
    parameter int KELIME_BIT = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     we,
    input  logic [VBY_MASKE_BIT-1:0] maske,
    input  logic [KELIME_BIT-1:0]    adr,
    input  logic [VBY_VERI_BIT-1:0]  yaz_veri,
    output logic [VBY_VERI_BIT-1:0]  oku_veri
);

    logic [VBY_VERI_BIT-1:0] bellek [2**KELIME_BIT];
    logic [VBY_VERI_BIT-1:0] bit_maske;

    assign bit_maske = maske_genislet(maske);

    always_ff @(posedge clk) begin
        if (en && we) begin
            bellek[adr] <= (bellek[adr] & ~bit_maske) | (yaz_veri & bit_maske);
        end
    end

    // Read port sees the old word on a store edge; only the read register is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oku_veri <= '0;
        end else if (en) begin
            oku_veri <= bellek[adr];
        end
    end

endmodule

// File: rtl/veri_bellek_yanitlayici.sv
// rtl/veri_bellek_yanitlayici.sv - BIB data-memory responder with programmable stall; VBY_ADRES_DENETIM_EN adds window check
module veri_bellek_yanitlayici
    import veri_bellek_yanitlayici_pkg::*;
#(
    parameter int          ADRES_BIT = 12,
    parameter int          BEKLEME   = 2,
    parameter logic [31:0] TABAN     = 32'h4000_0000
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    veri_bellek_yanitlayici_if.slave    bib
);

    localparam int KELIME_BIT = ADRES_BIT - 2;
    localparam logic [3:0] SAYAC_YUK = (BEKLEME > 0) ? 4'(BEKLEME - 1) : 4'd0;

    vby_durum_t durum, sonraki;
    logic [3:0] sayac, sayac_sonraki;
    logic       yukle;

    logic [KELIME_BIT-1:0]    istek_adr_r;
    logic [VBY_VERI_BIT-1:0]  istek_veri_r;
    logic [VBY_MASKE_BIT-1:0] istek_maske_r;
    logic                     istek_yaz_r;

    logic [KELIME_BIT-1:0]    etkin_adr;
    logic [VBY_VERI_BIT-1:0]  etkin_veri;
    logic [VBY_MASKE_BIT-1:0] etkin_maske;
    logic                     etkin_yaz;
    logic                     etkin_disi;
    logic                     sram_en;
    logic [VBY_VERI_BIT-1:0]  sram_oku;

    logic unused_bitler;
    assign unused_bitler = ^{bib.bib_adr_i[31:ADRES_BIT], bib.bib_adr_i[1:0], TABAN};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            durum <= VBY_BOSTA;
            sayac <= '0;
        end else begin
            durum <= sonraki;
            sayac <= sayac_sonraki;
        end
    end

    always_comb begin
        sonraki       = durum;
        sayac_sonraki = sayac;
        yukle         = 1'b0;
        case (durum)
            VBY_BOSTA: begin
                if (bib.bib_sec_i) begin
                    yukle = 1'b1;
                    if (BEKLEME > 0) begin
                        sonraki       = VBY_BEKLE;
                        sayac_sonraki = SAYAC_YUK;
                    end else begin
                        sonraki = VBY_YANIT;
                    end
                end
            end
            VBY_BEKLE: begin
                if (sayac == 4'd0) begin
                    sonraki = VBY_YANIT;
                end else begin
                    sayac_sonraki = sayac - 4'd1;
                end
            end
            VBY_YANIT: sonraki = VBY_BOSTA;
            default:   sonraki = VBY_BOSTA;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            istek_adr_r   <= '0;
            istek_veri_r  <= '0;
            istek_maske_r <= '0;
            istek_yaz_r   <= 1'b0;
        end else if (yukle) begin
            istek_adr_r   <= bib.bib_adr_i[ADRES_BIT-1:2];
            istek_veri_r  <= bib.bib_veri_i;
            istek_maske_r <= bib.bib_veri_maske_i;
            istek_yaz_r   <= bib.bib_yaz_gecerli_i;
        end
    end

    // With BEKLEME=0 the SRAM is accessed on the accept edge, before the latches hold the request.
    always_comb begin
        if (durum == VBY_BOSTA) begin
            etkin_adr   = bib.bib_adr_i[ADRES_BIT-1:2];
            etkin_veri  = bib.bib_veri_i;
            etkin_maske = bib.bib_veri_maske_i;
            etkin_yaz   = bib.bib_yaz_gecerli_i;
        end else begin
            etkin_adr   = istek_adr_r;
            etkin_veri  = istek_veri_r;
            etkin_maske = istek_maske_r;
            etkin_yaz   = istek_yaz_r;
        end
    end

`ifdef VBY_ADRES_DENETIM_EN
    logic canli_disi;
    logic pencere_disi_r;
    logic hata_r;

    assign canli_disi = (bib.bib_adr_i[31:ADRES_BIT] != TABAN[31:ADRES_BIT]);
    assign etkin_disi = (durum == VBY_BOSTA) ? canli_disi : pencere_disi_r;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pencere_disi_r <= 1'b0;
            hata_r         <= 1'b0;
        end else begin
            if (yukle) begin
                pencere_disi_r <= canli_disi;
            end
            if (sram_en) begin
                hata_r <= etkin_disi;
            end
        end
    end

    assign bib.bib_hata_o = (durum == VBY_YANIT) && hata_r;
    assign bib.bib_veri_o = bib.bib_hata_o ? '0 : sram_oku;
`else
    assign etkin_disi     = 1'b0;
    assign bib.bib_hata_o = 1'b0;
    assign bib.bib_veri_o = sram_oku;
`endif

    assign sram_en = (sonraki == VBY_YANIT);

    assign bib.bib_durdur_o = rst_i &&
                              (((durum == VBY_BOSTA) && bib.bib_sec_i) || (durum == VBY_BEKLE));

    veri_bellek_sram #(
        .KELIME_BIT (KELIME_BIT)
    ) u_sram (
        .clk      (clk_i),
        .rst_n    (rst_i),
        .en       (sram_en),
        .we       (etkin_yaz && !etkin_disi),
        .maske    (etkin_maske),
        .adr      (etkin_adr),
        .yaz_veri (etkin_veri),
        .oku_veri (sram_oku)
    );

endmodule
